// File: rtl/hc164_display_scanner_pkg.sv
// Shared scanner types: FSM state encoding, segment bit positions, hex-to-segment table.
// Pure declarations, no logic; no backpressure concerns.
package hc164_display_scanner_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_REQ       = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_DWELL     = 3'd5,
      ST_NEXT      = 3'd6
   } state_t;

   // Segment bits ordered g..a.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hc164_display_scanner_seg7_encoder.sv
// Nibble + dp + blank -> segment byte, polarity applied last.
// Combinational, zero latency; no handshake.
module hc164_display_scanner_seg7_encoder
   import hc164_display_scanner_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);

   logic [7:0] raw;

   always_comb begin
      raw = '0;
      if (!blank) begin
         raw[SEG_G:SEG_A] = hex_to_seg(nibble);
         raw[SEG_DP]      = dp;
      end
      seg = SEG_ACTIVE_LOW ? ~raw : raw;
   end

endmodule

// File: rtl/hc164_display_scanner.sv
// Multiplexed display refresh: one Wishbone write per digit, then a fixed dwell with its common on.
// First strobe two cycles after enable; stalls indefinitely on a slave that stalls or never acks.
module hc164_display_scanner
   import hc164_display_scanner_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DWELL_CYCLES   = 25000,
   parameter int DWELL_WIDTH    = 15,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_enable,
   input  logic [4*NUM_DIGITS-1:0] i_value,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic [NUM_DIGITS-1:0]   i_blank,
   output logic                    o_wb_cyc,
   output logic                    o_wb_stb,
   output logic [7:0]              o_wb_data,
   input  logic                    i_wb_ack,
   input  logic                    i_wb_stall,
   output logic [NUM_DIGITS-1:0]   o_digit_en,
   output logic                    o_frame_stb
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DWELL_WIDTH-1:0] DWELL_LAST = DWELL_WIDTH'(DWELL_CYCLES - 1);

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [DWELL_WIDTH-1:0]  dwell_cnt;
   logic [4*NUM_DIGITS-1:0] snap_value;
   logic [NUM_DIGITS-1:0]   snap_dp, snap_blank;
   logic                    snap_en;
   logic [7:0]              enc_byte;

   hc164_display_scanner_seg7_encoder #(
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_enc (
      .nibble (snap_value[{idx, 2'b00} +: 4]),
      .dp     (snap_dp[idx]),
      .blank  (snap_blank[idx]),
      .seg    (enc_byte)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      snap_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_enable) begin
               snap_en   = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD:  state_nxt = ST_REQ;
         ST_REQ: begin
            if (!i_wb_stall) state_nxt = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (i_wb_ack) state_nxt = i_wb_stall ? ST_WAIT_DONE : ST_DWELL;
         end
         ST_WAIT_DONE: begin
            if (!i_wb_stall) state_nxt = ST_DWELL;
         end
         ST_DWELL: begin
            if (dwell_cnt == DWELL_LAST) state_nxt = ST_NEXT;
         end
         ST_NEXT: begin
            // Inputs are only re-sampled at the frame boundary so a frame is always coherent.
            if (idx == LAST_IDX) begin
               idx_nxt = '0;
               if (i_enable) begin
                  snap_en   = 1'b1;
                  state_nxt = ST_LOAD;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               idx_nxt   = idx + 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         dwell_cnt   <= '0;
         snap_value  <= '0;
         snap_dp     <= '0;
         snap_blank  <= '0;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
         o_wb_data   <= '0;
         o_digit_en  <= '0;
         o_frame_stb <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         dwell_cnt <= (state == ST_DWELL) ? dwell_cnt + 1'b1 : '0;
         if (snap_en) begin
            snap_value <= i_value;
            snap_dp    <= i_dp;
            snap_blank <= i_blank;
         end
         // Outputs decode the next state so they line up with the state register.
         o_wb_cyc <= (state_nxt == ST_REQ) || (state_nxt == ST_WAIT_ACK);
         o_wb_stb <= (state_nxt == ST_REQ);
         if (state_nxt == ST_IDLE)
            o_wb_data <= '0;
         else if (state == ST_LOAD)
            o_wb_data <= enc_byte;
         o_digit_en  <= (state_nxt == ST_DWELL) ? (NUM_DIGITS'(1) << idx) : '0;
         o_frame_stb <= (state_nxt == ST_NEXT) && (idx == LAST_IDX);
      end
   end

endmodule

// File: tb/tb_hc164_display_scanner.sv
// Directed bench: two scanner instances (normal and inverted segments), each driven by a shifter model.
module tb_hc164_display_scanner;

   localparam int SHIFT_CYC = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  en;
   logic [15:0] value;
   logic [3:0]  dp, blank;

   logic        cyc0, stb0, ack0, stall0, fs0;
   logic [7:0]  dat0;
   logic [3:0]  den0;
   logic        cyc1, stb1, ack1, stall1, fs1;
   logic [7:0]  dat1;
   logic [3:0]  den1;

   hc164_display_scanner #(
      .NUM_DIGITS(4), .DWELL_CYCLES(3), .DWELL_WIDTH(2), .SEG_ACTIVE_LOW(1'b0)
   ) dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_enable(en[0]), .i_value(value), .i_dp(dp),
      .i_blank(blank), .o_wb_cyc(cyc0), .o_wb_stb(stb0), .o_wb_data(dat0),
      .i_wb_ack(ack0), .i_wb_stall(stall0), .o_digit_en(den0), .o_frame_stb(fs0)
   );

   hc164_display_scanner #(
      .NUM_DIGITS(4), .DWELL_CYCLES(3), .DWELL_WIDTH(2), .SEG_ACTIVE_LOW(1'b1)
   ) dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_enable(en[1]), .i_value(value), .i_dp(dp),
      .i_blank(blank), .o_wb_cyc(cyc1), .o_wb_stb(stb1), .o_wb_data(dat1),
      .i_wb_ack(ack1), .i_wb_stall(stall1), .o_digit_en(den1), .o_frame_stb(fs1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   logic [7:0] wr_q0[$];
   logic [7:0] wr_q1[$];
   logic [3:0] en_q[$];
   int         len_q[$];
   int         fr_cnt[2];
   int         ghost     = 0;
   time        ack_t     = 0;
   int         last_gap  = 0;
   int         hold_left = 0;
   int         hold_seen = 0;
   int         hold_bad  = 0;
   bit         in_hold   = 1'b0;
   logic [7:0] hold_dat  = 8'h00;
   bit         fast_ack  = 1'b0;
   bit         acc0      = 1'b0;
   bit         acc1      = 1'b0;
   int         busy      = 0;

   // Shifter model for dut0: optional stall on a fresh request, ack one cycle after acceptance,
   // then either stall for SHIFT_CYC cycles or release immediately.
   initial begin
      stall0 = 1'b0;
      ack0   = 1'b0;
      forever begin
         @(negedge clk);
         ack0 = 1'b0;
         if (!rst_n) begin
            stall0 = 1'b0; acc0 = 1'b0; busy = 0; in_hold = 1'b0;
         end else if (acc0) begin
            acc0 = 1'b0; ack0 = 1'b1; ack_t = $time;
            if (fast_ack) stall0 = 1'b0;
            else begin stall0 = 1'b1; busy = SHIFT_CYC - 1; end
         end else if (busy > 0) begin
            stall0 = 1'b1; busy--;
         end else if (cyc0 && stb0) begin
            if (hold_left > 0) begin
               if (!in_hold) begin in_hold = 1'b1; hold_dat = dat0; end
               else if (dat0 != hold_dat) hold_bad++;
               hold_seen++; hold_left--; stall0 = 1'b1;
            end else begin
               if (in_hold && dat0 != hold_dat) hold_bad++;
               in_hold = 1'b0; stall0 = 1'b0; acc0 = 1'b1;
               wr_q0.push_back(dat0);
            end
         end else begin
            if (in_hold) hold_bad++;
            stall0 = 1'b0;
         end
      end
   end

   initial begin
      stall1 = 1'b0;
      ack1   = 1'b0;
      forever begin
         @(negedge clk);
         ack1 = 1'b0;
         if (!rst_n) acc1 = 1'b0;
         else if (acc1) begin acc1 = 1'b0; ack1 = 1'b1; end
         else if (cyc1 && stb1) begin acc1 = 1'b1; wr_q1.push_back(dat1); end
      end
   end

   // Output monitor: frame pulses, digit-enable runs, ack-to-dwell gap, ghosting.
   initial begin
      logic [3:0] prev;
      int         run;
      prev = '0;
      run  = 0;
      forever begin
         @(negedge clk);
         if (fs0) fr_cnt[0]++;
         if (fs1) fr_cnt[1]++;
         if (den0 != 0 && cyc0) ghost++;
         if (den1 != 0 && cyc1) ghost++;
         if (den0 != 0) begin
            if (prev == 0) begin last_gap = int'(($time - ack_t) / 10); run = 1; end
            else if (den0 == prev) run++;
            else begin en_q.push_back(prev); len_q.push_back(run); run = 1; end
         end else if (prev != 0) begin
            en_q.push_back(prev); len_q.push_back(run);
         end
         prev = den0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_frame_cnt(input int pol, input int target);
      int t;
      t = 0;
      while (fr_cnt[pol] < target && t < 1000) begin @(negedge clk); t++; end
      check($sformatf("frame_done_p%0d", pol), 32'(fr_cnt[pol] >= target), 32'd1);
      repeat (12) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  blank;
      int          pol;
      logic [31:0] exp;   // byte k = expected write for digit k
   } vec_t;

   initial begin
      vec_t        vecs[6];
      int          start, t, p;
      logic [31:0] act;

      vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 0, 32'h065B4F66};
      vecs[1] = '{16'hFA8E, 4'b0010, 4'b1000, 1, 32'hFF880086};
      vecs[2] = '{16'h7C90, 4'b1001, 4'b0000, 0, 32'h87396FBF};
      vecs[3] = '{16'h56BD, 4'b0100, 4'b0010, 0, 32'h6DFD005E};
      vecs[4] = '{16'h0000, 4'b1111, 4'b0101, 1, 32'h40FF40FF};
      vecs[5] = '{16'h8F31, 4'b0000, 4'b0000, 1, 32'h808EB0F9};

      rst_n = 1'b0; en = '0; value = '0; dp = '0; blank = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs_0", 32'({cyc0, stb0, fs0, den0, dat0}), 32'd0);
      check("reset_outputs_1", 32'({cyc1, stb1, fs1, den1, dat1}), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_quiet", 32'({cyc0, stb0, den0, cyc1, stb1, den1}), 32'd0);

      // Stalled first request, fast ack, and first-strobe latency.
      value = 16'h1234; fast_ack = 1'b1; hold_left = 5; hold_seen = 0; hold_bad = 0;
      wr_q0.delete(); en_q.delete(); len_q.delete();
      start = fr_cnt[0];
      en[0] = 1'b1;
      @(negedge clk); en[0] = 1'b0;
      check("load_cycle_stb", 32'({cyc0, stb0}), 32'd0);
      @(negedge clk);
      check("first_stb", 32'({cyc0, stb0}), 32'd3);
      wait_frame_cnt(0, start + 1);
      check("hold_cycles", 32'(hold_seen), 32'd5);
      check("hold_stable", 32'(hold_bad), 32'd0);
      check("hold_writes", 32'(wr_q0.size()), 32'd4);
      check("hold_first_byte", 32'((wr_q0.size() > 0) ? wr_q0[0] : 8'hEE), 32'h66);
      check("fast_ack_gap", 32'(last_gap), 32'd1);
      fast_ack = 1'b0;

      for (int v = 0; v < 6; v++) begin
         p = vecs[v].pol;
         value = vecs[v].value; dp = vecs[v].dp; blank = vecs[v].blank;
         if (p == 0) begin wr_q0.delete(); en_q.delete(); len_q.delete(); end
         else wr_q1.delete();
         start = fr_cnt[p];
         en[p] = 1'b1;
         @(negedge clk); en = '0;
         wait_frame_cnt(p, start + 1);
         check($sformatf("vec%0d_frame_pulses", v), 32'(fr_cnt[p] - start), 32'd1);
         check($sformatf("vec%0d_writes", v),
               32'((p == 0) ? wr_q0.size() : wr_q1.size()), 32'd4);
         for (int k = 0; k < 4; k++) begin
            act = 32'hDEAD;
            if (p == 0 && k < wr_q0.size()) act = 32'(wr_q0[k]);
            if (p == 1 && k < wr_q1.size()) act = 32'(wr_q1[k]);
            check($sformatf("vec%0d_byte%0d", v, k), act, 32'(vecs[v].exp[8*k +: 8]));
         end
         if (p == 0) begin
            check($sformatf("vec%0d_dwell_runs", v), 32'(en_q.size()), 32'd4);
            for (int k = 0; k < 4 && k < en_q.size(); k++) begin
               check($sformatf("vec%0d_den%0d", v, k), 32'(en_q[k]), 32'(1 << k));
               check($sformatf("vec%0d_dwell_len%0d", v, k), 32'(len_q[k]), 32'd3);
            end
            check($sformatf("vec%0d_shift_gap", v), 32'(last_gap), 32'(SHIFT_CYC + 1));
         end
         repeat (2) @(negedge clk);
      end

      // Snapshot coherency: value changes while digit 1 dwells.
      value = 16'h1111; dp = '0; blank = '0;
      wr_q0.delete();
      start = fr_cnt[0];
      en[0] = 1'b1;
      t = 0;
      while (den0 != 4'b0010 && t < 500) begin @(negedge clk); t++; end
      check("snap_reach_digit1", 32'(den0), 32'h2);
      value = 16'h2222;
      t = 0;
      while (wr_q0.size() < 5 && t < 500) begin @(negedge clk); t++; end
      en[0] = 1'b0;
      wait_frame_cnt(0, start + 2);
      check("snap_writes", 32'(wr_q0.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         check($sformatf("snap_byte%0d", k), 32'((k < wr_q0.size()) ? wr_q0[k] : 8'hEE),
               (k < 4) ? 32'h06 : 32'h5B);

      // Reset while the third digit is shifting.
      value = 16'h1234;
      wr_q0.delete();
      en[0] = 1'b1;
      t = 0;
      while (wr_q0.size() < 3 && t < 500) begin @(negedge clk); #1; t++; end
      t = 0;
      while (!ack0 && t < 50) begin @(negedge clk); #1; t++; end
      check("rst_reach_ack", 32'(ack0), 32'd1);
      @(negedge clk);
      check("wait_done_state", 32'({cyc0, stb0, den0, fs0, dat0}), 32'h5B);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_shift_reset", 32'({cyc0, stb0, den0, fs0, dat0}), 32'd0);
      rst_n = 1'b1;
      wr_q0.delete(); en_q.delete(); len_q.delete();
      t = 0;
      while ((wr_q0.size() < 1 || en_q.size() < 1) && t < 500) begin @(negedge clk); t++; end
      check("restart_byte", 32'((wr_q0.size() > 0) ? wr_q0[0] : 8'hEE), 32'h66);
      check("restart_digit", 32'((en_q.size() > 0) ? en_q[0] : 4'hF), 32'h1);
      en[0] = 1'b0;
      wait_frame_cnt(0, fr_cnt[0] + 1);
      check("idle_after_restart", 32'({cyc0, stb0, den0}), 32'd0);

      check("no_ghosting", 32'(ghost), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
